// File: rtl/huffman_bit_packer_if.sv
// huffman_bit_packer_if
//   Bundles the table-load, symbol, flush and byte handshakes of the
//   Huffman bit packer. The clock and reset are not part of the bundle.
//   When HUFF_PACK_BITCNT_EN is defined, bit_count[23:0] is also carried.
//
//   Modports:
//     master : the side that loads the table, offers symbols and consumes bytes
//     slave  : the packer itself
interface huffman_bit_packer_if #(
    parameter int SYM_W  = 8,
    parameter int CODE_W = 17,
    parameter int LEN_W  = 4
);
    // Table load
    logic              tbl_valid;
    logic [SYM_W-1:0]  tbl_symbol;
    logic [LEN_W-1:0]  tbl_length;
    logic [CODE_W-1:0] tbl_code;
    // Symbol stream
    logic              sym_valid;
    logic [SYM_W-1:0]  sym_in;
    logic              sym_ready;
    logic              flush;
    // Byte stream
    logic [7:0]        byte_out;
    logic              byte_valid;
    logic              byte_ready;
    // Status
    logic              done;
    logic              err;
`ifdef HUFF_PACK_BITCNT_EN
    logic [23:0]       bit_count;
`endif

    modport master (
        output tbl_valid, tbl_symbol, tbl_length, tbl_code,
        output sym_valid, sym_in, flush, byte_ready,
        input  sym_ready, byte_out, byte_valid, done, err
`ifdef HUFF_PACK_BITCNT_EN
        , input bit_count
`endif
    );

    modport slave (
        input  tbl_valid, tbl_symbol, tbl_length, tbl_code,
        input  sym_valid, sym_in, flush, byte_ready,
        output sym_ready, byte_out, byte_valid, done, err
`ifdef HUFF_PACK_BITCNT_EN
        , output bit_count
`endif
    );
endinterface

// File: rtl/huffman_bit_packer.sv
// huffman_bit_packer
//   Loads a per-symbol {length, code} table, then packs the codewords of a
//   symbol stream MSB-first into bytes. A flush zero-pads the last partial
//   byte, drains the buffer and reports done. Symbols with no code (length 0)
//   are swallowed and raise a sticky err.
//
//   Ports:
//     clock : rising-edge clock
//     rst   : asynchronous, active-low reset
//     bus   : huffman_bit_packer_if.slave (table load, symbols, flush,
//             bytes, done, err)
//
//   Optional feature: define HUFF_PACK_BITCNT_EN to add bus.bit_count, a
//   saturating count of code bits appended (padding excluded), cleared by
//   reset and when a new table load starts from DONE.
module huffman_bit_packer #(
    parameter int SYM_W  = 8,
    parameter int CODE_W = 17,
    parameter int LEN_W  = 4
) (
    input  logic                  clock,
    input  logic                  rst,
    huffman_bit_packer_if.slave   bus
);

    localparam int DEPTH = 2 ** SYM_W;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Code table
    logic [LEN_W-1:0]  len_tbl_q  [DEPTH];
    logic [CODE_W-1:0] code_tbl_q [DEPTH];

    // Control and bit buffer
    state_t      state_q,      state_d;
    logic [4:0]  cnt_q,        cnt_d;
    logic [23:0] acc_q,        acc_d;
    logic        loaded_q,     loaded_d;
    logic        err_q,        err_d;
    logic        done_q,       done_d;
    logic        sym_ready_q,  sym_ready_d;
    logic        byte_valid_q, byte_valid_d;
`ifdef HUFF_PACK_BITCNT_EN
    logic [23:0] bit_count_q,  bit_count_d;
    logic [24:0] bit_sum;
`endif

    logic              tbl_we;
    logic              accept;
    logic              pop;
    logic [LEN_W-1:0]  lk_len;
    logic [CODE_W-1:0] lk_code;
    logic [23:0]       acc_sh;
    logic [4:0]        cnt_sh;

    // Places the low len bits of code directly behind the used bits of a
    // left-aligned 24-bit buffer holding used bits.
    function automatic logic [23:0] place_code(
        input logic [CODE_W-1:0] code,
        input logic [LEN_W-1:0]  len,
        input logic [4:0]        used
    );
        logic [CODE_W-1:0] masked;
        logic [23:0]       wide;
        logic [5:0]        shamt;
        masked = code & ~({CODE_W{1'b1}} << len);
        wide   = 24'(masked);
        shamt  = 6'd24 - 6'(used) - 6'(len);
        return wide << shamt;
    endfunction

    assign lk_len  = len_tbl_q[bus.sym_in];
    assign lk_code = code_tbl_q[bus.sym_in];
    assign accept  = bus.sym_valid && sym_ready_q;
    assign pop     = byte_valid_q && bus.byte_ready;
    assign tbl_we  = bus.tbl_valid && ((state_q == ST_LOAD) || (state_q == ST_DONE));

    // Buffer after a byte handed downstream this cycle, if any
    assign acc_sh  = pop ? (acc_q << 8) : acc_q;
    assign cnt_sh  = pop ? (cnt_q - 5'd8) : cnt_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        loaded_d  = loaded_q;
        err_d     = err_q;
        done_d    = done_q;
`ifdef HUFF_PACK_BITCNT_EN
        bit_count_d = bit_count_q;
        bit_sum     = {1'b0, bit_count_q} + 25'(lk_len);
`endif
        case (state_q)
            ST_LOAD: begin
                if (bus.tbl_valid) begin
                    loaded_d = 1'b1;
                end else if (loaded_q) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_sh;
                acc_d = acc_sh;
                if (accept) begin
                    if (lk_len == '0) begin
                        err_d = 1'b1;
                    end else begin
                        acc_d = acc_sh | place_code(lk_code, lk_len, cnt_sh);
                        cnt_d = cnt_sh + 5'(lk_len);
`ifdef HUFF_PACK_BITCNT_EN
                        bit_count_d = bit_sum[24] ? 24'hFFFFFF : bit_sum[23:0];
`endif
                    end
                end
                if (bus.flush) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == 5'd0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (cnt_q < 5'd8) begin
                    // Zero bits already sit behind the data; only the count moves
                    cnt_d = 5'd8;
                end else begin
                    cnt_d = cnt_sh;
                    acc_d = acc_sh;
                end
            end
            ST_DONE: begin
                if (bus.tbl_valid) begin
                    state_d  = ST_LOAD;
                    done_d   = 1'b0;
                    loaded_d = 1'b1;
`ifdef HUFF_PACK_BITCNT_EN
                    bit_count_d = '0;
`endif
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase

        // Outputs are registered from next-state values so they never
        // depend combinationally on byte_ready.
        sym_ready_d  = (state_d == ST_RUN) && (cnt_d <= 5'd9);
        byte_valid_d = (cnt_d >= 5'd8);
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_LOAD;
            cnt_q        <= '0;
            acc_q        <= '0;
            loaded_q     <= 1'b0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            sym_ready_q  <= 1'b0;
            byte_valid_q <= 1'b0;
`ifdef HUFF_PACK_BITCNT_EN
            bit_count_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            loaded_q     <= loaded_d;
            err_q        <= err_d;
            done_q       <= done_d;
            sym_ready_q  <= sym_ready_d;
            byte_valid_q <= byte_valid_d;
`ifdef HUFF_PACK_BITCNT_EN
            bit_count_q  <= bit_count_d;
`endif
        end
    end

    // Lengths reset to 0 so every symbol starts out "no code"
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                len_tbl_q[i] <= '0;
            end
        end else if (tbl_we) begin
            len_tbl_q[bus.tbl_symbol] <= bus.tbl_length;
        end
    end

    // Codes are only meaningful where the length is non-zero; no reset needed
    always_ff @(posedge clock) begin
        if (tbl_we) begin
            code_tbl_q[bus.tbl_symbol] <= bus.tbl_code;
        end
    end

    assign bus.sym_ready  = sym_ready_q;
    assign bus.byte_out   = acc_q[23:16];
    assign bus.byte_valid = byte_valid_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
`ifdef HUFF_PACK_BITCNT_EN
    assign bus.bit_count  = bit_count_q;
`endif

endmodule

// File: tb/tb_huffman_bit_packer.sv
// tb_huffman_bit_packer
//   Directed bench for huffman_bit_packer. Table used throughout:
//   A=0x41 -> "10", B=0x42 -> "0", C=0x43 -> "111".
module tb_huffman_bit_packer;

    localparam logic [7:0] SYM_A = 8'h41;
    localparam logic [7:0] SYM_B = 8'h42;
    localparam logic [7:0] SYM_C = 8'h43;
    localparam logic [7:0] SYM_X = 8'h5A;

    logic clock;
    logic rst;
    int   checks;
    int   failures;

    huffman_bit_packer_if #(.SYM_W(8), .CODE_W(17), .LEN_W(4)) bus ();

    huffman_bit_packer #(.SYM_W(8), .CODE_W(17), .LEN_W(4)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load_entry(input logic [7:0] s, input logic [3:0] len, input logic [16:0] code);
        bus.tbl_valid  = 1'b1;
        bus.tbl_symbol = s;
        bus.tbl_length = len;
        bus.tbl_code   = code;
        step();
        bus.tbl_valid  = 1'b0;
    endtask

    // Offers one symbol and returns just after the edge that accepts it
    task automatic send_sym(input logic [7:0] s);
        int budget;
        budget = 20;
        bus.sym_valid = 1'b1;
        bus.sym_in    = s;
        while (!bus.sym_ready && budget > 0) begin
            step();
            budget--;
        end
        checks++;
        if (budget == 0) begin
            failures++;
            $display("FAIL send_sym_timeout sym=%h sym_ready=%b required=1", s, bus.sym_ready);
        end else begin
            step();
        end
        bus.sym_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        checks++; if (bus.sym_ready !== 1'b0) begin failures++; $display("FAIL reset_sym_ready got=%b exp=0", bus.sym_ready); end
        checks++; if (bus.byte_valid !== 1'b0) begin failures++; $display("FAIL reset_byte_valid got=%b exp=0", bus.byte_valid); end
        checks++; if (bus.byte_out !== 8'h00) begin failures++; $display("FAIL reset_byte_out got=%h exp=00", bus.byte_out); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.err); end
`ifdef HUFF_PACK_BITCNT_EN
        checks++; if (bus.bit_count !== 24'd0) begin failures++; $display("FAIL reset_bit_count got=%0d exp=0", bus.bit_count); end
`endif
        rst = 1'b1;
        step();
    endtask

    task automatic test_load_empty();
        repeat (4) step();
        checks++; if (bus.sym_ready !== 1'b0) begin failures++; $display("FAIL empty_load_sym_ready got=%b exp=0", bus.sym_ready); end
        // flush outside RUN must not start a drain
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        step();
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL load_flush_ignored done=%b exp=0", bus.done); end
    endtask

    task automatic test_load_table();
        load_entry(SYM_A, 4'd2, 17'b10);
        load_entry(SYM_B, 4'd1, 17'b0);
        load_entry(SYM_C, 4'd3, 17'b111);
        checks++; if (bus.sym_ready !== 1'b0) begin failures++; $display("FAIL loading_sym_ready got=%b exp=0", bus.sym_ready); end
        step();
        checks++; if (bus.sym_ready !== 1'b1) begin failures++; $display("FAIL run_sym_ready got=%b exp=1", bus.sym_ready); end
    endtask

    task automatic test_flush();
        int budget;
        bus.byte_ready = 1'b1;
        send_sym(SYM_A);
        send_sym(SYM_B);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        checks++; if (bus.sym_ready !== 1'b0) begin failures++; $display("FAIL flush_sym_ready got=%b exp=0", bus.sym_ready); end
        budget = 10;
        while (!bus.byte_valid && budget > 0) begin step(); budget--; end
        checks++; if (bus.byte_valid !== 1'b1) begin failures++; $display("FAIL flush_byte_timeout byte_valid=%b exp=1", bus.byte_valid); end
        checks++; if (bus.byte_out !== 8'h80) begin failures++; $display("FAIL flush_byte_out got=%h exp=80", bus.byte_out); end
        budget = 10;
        while (!bus.done && budget > 0) begin step(); budget--; end
        checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL flush_done got=%b exp=1", bus.done); end
        checks++; if (bus.byte_valid !== 1'b0) begin failures++; $display("FAIL done_byte_valid got=%b exp=0", bus.byte_valid); end
`ifdef HUFF_PACK_BITCNT_EN
        checks++; if (bus.bit_count !== 24'd3) begin failures++; $display("FAIL flush_bit_count got=%0d exp=3", bus.bit_count); end
`endif
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        step();
        checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL done_flush_ignored done=%b exp=1", bus.done); end
    endtask

    task automatic test_done_reload();
        load_entry(SYM_A, 4'd2, 17'b10);
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reload_done got=%b exp=0", bus.done); end
        checks++; if (bus.sym_ready !== 1'b0) begin failures++; $display("FAIL reload_sym_ready got=%b exp=0", bus.sym_ready); end
`ifdef HUFF_PACK_BITCNT_EN
        checks++; if (bus.bit_count !== 24'd0) begin failures++; $display("FAIL reload_bit_count got=%0d exp=0", bus.bit_count); end
`endif
        step();
        checks++; if (bus.sym_ready !== 1'b1) begin failures++; $display("FAIL reload_run_sym_ready got=%b exp=1", bus.sym_ready); end
    endtask

    // B and C were not rewritten in the reload, so they must still be present
    task automatic test_pack_basic();
        bus.byte_ready = 1'b1;
        send_sym(SYM_A);
        send_sym(SYM_B);
        send_sym(SYM_C);
        checks++; if (bus.byte_valid !== 1'b0) begin failures++; $display("FAIL basic_partial_valid got=%b exp=0", bus.byte_valid); end
        send_sym(SYM_A);
        checks++; if (bus.byte_valid !== 1'b1) begin failures++; $display("FAIL basic_byte_valid got=%b exp=1", bus.byte_valid); end
        checks++; if (bus.byte_out !== 8'h9E) begin failures++; $display("FAIL basic_byte_out got=%h exp=9e", bus.byte_out); end
        step();
        checks++; if (bus.byte_valid !== 1'b0) begin failures++; $display("FAIL basic_drained got=%b exp=0", bus.byte_valid); end
        checks++; if (bus.sym_ready !== 1'b1) begin failures++; $display("FAIL basic_sym_ready got=%b exp=1", bus.sym_ready); end
    endtask

    task automatic test_back_pressure();
        bus.byte_ready = 1'b0;
        send_sym(SYM_C);
        send_sym(SYM_C);
        send_sym(SYM_C);
        checks++; if (bus.byte_valid !== 1'b1) begin failures++; $display("FAIL bp_byte_valid got=%b exp=1", bus.byte_valid); end
        checks++; if (bus.byte_out !== 8'hFF) begin failures++; $display("FAIL bp_byte_out got=%h exp=ff", bus.byte_out); end
        checks++; if (bus.sym_ready !== 1'b1) begin failures++; $display("FAIL bp_cnt9_sym_ready got=%b exp=1", bus.sym_ready); end
        send_sym(SYM_C);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.byte_valid !== 1'b1 || bus.byte_out !== 8'hFF || bus.sym_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d valid=%b out=%h ready=%b exp=1/ff/0", i, bus.byte_valid, bus.byte_out, bus.sym_ready);
            end
            step();
        end
        bus.byte_ready = 1'b1;
        step();
        checks++; if (bus.byte_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", bus.byte_valid); end
        checks++; if (bus.sym_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", bus.sym_ready); end
        // 1111 + 10 0 10 -> 11111001 with one bit left over
        send_sym(SYM_A);
        send_sym(SYM_B);
        send_sym(SYM_A);
        checks++; if (bus.byte_out !== 8'hF9 || bus.byte_valid !== 1'b1) begin failures++; $display("FAIL bp_drain_byte got=%h/%b exp=f9/1", bus.byte_out, bus.byte_valid); end
    endtask

    task automatic test_unloaded_symbol();
        send_sym(SYM_X);
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL unloaded_err got=%b exp=1", bus.err); end
        checks++; if (bus.byte_valid !== 1'b0) begin failures++; $display("FAIL unloaded_valid got=%b exp=0", bus.byte_valid); end
        // Leftover "0", no bits from 0x5A, then 10 111 0 10 -> 01011101
        send_sym(SYM_A);
        send_sym(SYM_C);
        send_sym(SYM_B);
        send_sym(SYM_A);
        checks++; if (bus.byte_out !== 8'h5D || bus.byte_valid !== 1'b1) begin failures++; $display("FAIL unloaded_nobits got=%h/%b exp=5d/1", bus.byte_out, bus.byte_valid); end
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", bus.err); end
    endtask

    task automatic test_reset_midstream();
        send_sym(SYM_C);
        send_sym(SYM_B);
        checks++; if (bus.byte_valid !== 1'b0) begin failures++; $display("FAIL mid_pre_valid got=%b exp=0", bus.byte_valid); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (bus.sym_ready !== 1'b0 || bus.byte_valid !== 1'b0 || bus.byte_out !== 8'h00) begin
            failures++; $display("FAIL mid_reset_outputs ready=%b valid=%b out=%h exp=0/0/00", bus.sym_ready, bus.byte_valid, bus.byte_out);
        end
        checks++; if (bus.err !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL mid_reset_status err=%b done=%b exp=0/0", bus.err, bus.done); end
        step();
        step();
        rst = 1'b1;
        step();
        checks++; if (bus.sym_ready !== 1'b0 || bus.byte_valid !== 1'b0) begin failures++; $display("FAIL mid_after_reset ready=%b valid=%b exp=0/0", bus.sym_ready, bus.byte_valid); end
        load_entry(SYM_A, 4'd2, 17'b10);
        step();
        send_sym(SYM_A);
        send_sym(SYM_A);
        send_sym(SYM_A);
        send_sym(SYM_A);
        checks++; if (bus.byte_out !== 8'hAA || bus.byte_valid !== 1'b1) begin failures++; $display("FAIL mid_clean_byte got=%h/%b exp=aa/1", bus.byte_out, bus.byte_valid); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL mid_err_clear got=%b exp=0", bus.err); end
        // C was loaded before reset; its length must have been cleared
        send_sym(SYM_C);
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL mid_table_cleared err=%b exp=1", bus.err); end
        checks++; if (bus.byte_valid !== 1'b0) begin failures++; $display("FAIL mid_c_nobits valid=%b exp=0", bus.byte_valid); end
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst            = 1'b0;
        bus.tbl_valid  = 1'b0;
        bus.tbl_symbol = '0;
        bus.tbl_length = '0;
        bus.tbl_code   = '0;
        bus.sym_valid  = 1'b0;
        bus.sym_in     = '0;
        bus.flush      = 1'b0;
        bus.byte_ready = 1'b1;
        test_reset();
        test_load_empty();
        test_load_table();
        test_flush();
        test_done_reload();
        test_pack_basic();
        test_back_pressure();
        test_unloaded_symbol();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/huffman_bit_packer.md
HUFFMAN_BIT_PACKER -- requirements
Module: huffman_bit_packer

Interface
REQ-001 SHALL have parameter SYM_W, default 8: symbol width in bits; the table depth is 2^SYM_W entries.
REQ-002 SHALL have parameter CODE_W, default 17: codeword width in bits, matching the encoder code output.
REQ-003 SHALL have parameter LEN_W, default 4: code-length width in bits; legal lengths are 1..15.
REQ-004 SHALL have ports:
- clock  in  1: single clock; all state updates on the rising edge.
- rst  in  1: asynchronous, active-low reset.
- tbl_valid  in  1: qualifies one table entry in the same cycle.
- tbl_symbol  in  SYM_W: symbol being loaded.
- tbl_length  in  LEN_W: code length of that symbol.
- tbl_code  in  CODE_W: codeword; bit [len-1] is the first bit on the wire, bit 0 the last.
- sym_valid  in  1: a data symbol is offered.
- sym_in  in  SYM_W: data symbol.
- sym_ready  out  1: packer accepts sym_in this cycle.
- flush  in  1: one-cycle pulse ending the stream.
- byte_out  out  8: packed byte; the first stream bit is at byte bit 7.
- byte_valid  out  1: byte_out holds a complete byte.
- byte_ready  in  1: downstream consumes byte_out.
- done  out  1: level; stream fully drained.
- err  out  1: sticky; a symbol without a code was seen.

Function
REQ-005 SHALL hold a table of 2^SYM_W entries, each {length, code}; a reset entry has length 0.
REQ-006 SHALL implement the states LOAD, RUN, FLUSH and DONE; it enters LOAD on reset.
REQ-007 In LOAD, tbl_valid=1 SHALL write tbl_length and tbl_code at index tbl_symbol at the clock edge; a later write to the same symbol overwrites the earlier one.
REQ-008 SHALL move from LOAD to RUN on the first cycle with tbl_valid=0 after at least one entry is written; with zero entries written it SHALL stay in LOAD.
REQ-009 SHALL drive sym_ready=1 only in RUN with cnt<=9, where cnt is the number of buffered bits (0..24); sym_ready has no combinational path from byte_ready.
REQ-010 On sym_valid&&sym_ready, SHALL look up the table combinationally and append code[len-1:0] MSB-first behind the buffered bits at that same edge.
REQ-011 SHALL keep buffered bits left-aligned in a 24-bit register; byte_out SHALL equal acc[23:16] and byte_valid SHALL be (cnt>=8).
REQ-012 On byte_valid&&byte_ready, SHALL shift acc left by 8 and subtract 8 from cnt; a symbol accepted in the same cycle is appended after the shift (cnt_next = cnt-8+len).
REQ-013 byte_out and byte_valid SHALL stay stable while byte_valid=1 and byte_ready=0.
REQ-014 Latency: a symbol accepted at edge N that completes a byte SHALL give byte_valid=1 in the cycle after edge N.
REQ-015 A symbol whose table length is 0 SHALL be accepted, append no bits, and set err; err stays set until reset.
REQ-016 flush in RUN SHALL move the block to FLUSH; flush in any other state SHALL be ignored; a symbol accepted in the flush cycle is still packed.
REQ-017 In FLUSH, sym_ready SHALL be 0; when 1<=cnt<=7, the block SHALL zero-pad to cnt=8 in one cycle, then drain.
REQ-018 When FLUSH reaches cnt=0, the block SHALL move to DONE with done=1.
REQ-019 In DONE, tbl_valid=1 SHALL move to LOAD, clear done, and write that entry; table entries not rewritten are retained.

Reset
REQ-020 rst=0 SHALL immediately set: state=LOAD, cnt=0, acc=0, all table lengths=0, sym_ready=0, byte_valid=0, byte_out=0, done=0, err=0.
REQ-021 Reset asserted mid-stream SHALL discard all buffered bits without emitting a partial byte.

Configuration
REQ-022 With macro HUFF_PACK_BITCNT_EN defined, SHALL add output bit_count[23:0]: total code bits appended (padding excluded), saturating at 0xFFFFFF, cleared by reset and on DONE->LOAD; without the macro, the port and its counter SHALL be absent and all other behaviour is identical.

Verification
REQ-023 SHALL cover: load A(0x41):len2 code 2'b10, B(0x42):len1 code 0, C(0x43):len3 code 3'b111; stream A,B,C,A with byte_ready=1 -> one byte 0x9E, cnt=0.
REQ-024 SHALL cover: same table, stream A,B then flush -> byte 0x80 (padded), then done=1; with macro, bit_count=3.
REQ-025 SHALL cover: stream C,C,C with byte_ready=0 -> byte_valid=1 with byte_out=0xFF held stable and sym_ready=0 (cnt=9 is reached, then 9<=9 still allows one more C); after release, bytes drain correctly.
REQ-026 SHALL cover: symbol 0x5A never loaded -> accepted, no bits added, err=1 and stays 1.
REQ-027 SHALL cover: rst pulsed low mid-stream with cnt=5 -> no byte emitted, state LOAD, table lengths 0, outputs at reset values.
REQ-028 SHALL cover: tbl_valid low in LOAD with no entries loaded -> block stays in LOAD with sym_ready=0; after done, a new tbl_valid -> LOAD, done=0.
